// File: rtl/pg_port_controller_pkg.sv
// Shared types and constants for the per-router power-gating controller.
package pg_port_controller_pkg;

  localparam int NUM_PORTS           = 4;
  localparam int PORT_STAT_SIZE      = 2;
  // Epoch load per port must hold up to EPOCH_LEN (1024) events.
  localparam int PG_PORT_LOAD_SIZE   = 11;
  // Sum of four port loads.
  localparam int PG_ROUTER_LOAD_SIZE = 13;

  // Encoding is shared with the load tracker and the router datapath.
  typedef enum logic [PORT_STAT_SIZE-1:0] {
    ACTIVE   = 2'd0,
    INACTIVE = 2'd1,
    SLEEPING = 2'd2,
    WAKING   = 2'd3
  } port_stat_t;

  typedef logic [PG_PORT_LOAD_SIZE-1:0]   port_load_t;
  typedef logic [PG_ROUTER_LOAD_SIZE-1:0] router_load_t;

  // Width of the drain/power-up counter: enough for max(a, b) - 1, never 0.
  function automatic int lat_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pg_port_fsm.sv
// Gating state machine for one router port: state register, drain/power-up
// latency counter and the link power-switch output.
module pg_port_fsm
  import pg_port_controller_pkg::*;
#(
  parameter int SLEEP_LAT = 4,
  parameter int WAKE_LAT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gateReq,
  input  logic       wakeReq,
  input  logic       forceOn,
  output port_stat_t status,
  output logic       powerOn
);

  localparam int CNT_W = lat_width(SLEEP_LAT, WAKE_LAT);
  localparam logic [CNT_W-1:0] SLEEP_LOAD = CNT_W'(SLEEP_LAT - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_LAT - 1);

  port_stat_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter register; reset returns straight to ACTIVE.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (reset) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a wake request always beats a pending gate or drain.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACTIVE: begin
        if (gateReq && !wakeReq && !forceOn) begin
          state_d = SLEEPING;
          cnt_d   = SLEEP_LOAD;
        end
      end
      SLEEPING: begin
        if (wakeReq || forceOn) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = INACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      INACTIVE: begin
        if (wakeReq || forceOn) begin
          state_d = WAKING;
          cnt_d   = WAKE_LOAD;
        end
      end
      WAKING: begin
        // Power-up cannot be aborted once started.
        if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end

  assign status  = state_q;
  assign powerOn = (state_q != INACTIVE);

endmodule

// File: rtl/pg_port_controller.sv
// Per-router power-gating controller: epoch strobe generation, load-based
// gate/wake decisions and four per-port gating state machines.
module pg_port_controller
  import pg_port_controller_pkg::*;
#(
  parameter int EPOCH_LEN      = 1024,
  parameter int LOW_TH         = 8,
  parameter int HIGH_TH        = 16,
  parameter int ROUTER_HIGH_TH = 48,
  parameter int MIN_ACTIVE     = 2,
  parameter int SLEEP_LAT      = 4,
  parameter int WAKE_LAT       = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    gateEn,
  input  logic [NUM_PORTS-1:0]                    wakeReq,
  input  logic [NUM_PORTS*PG_PORT_LOAD_SIZE-1:0]  portLoad,
  input  logic [PG_ROUTER_LOAD_SIZE-1:0]          routerLoad,
  output logic                                    pgEnable,
  output logic [NUM_PORTS*PORT_STAT_SIZE-1:0]     portStatus,
  output logic [NUM_PORTS-1:0]                    portPowerOn
);

  localparam int EP_W = $clog2(EPOCH_LEN);
  localparam logic [EP_W-1:0]   EPOCH_LAST   = EP_W'(EPOCH_LEN - 1);
  localparam port_load_t        LOW_TH_L     = port_load_t'(LOW_TH);
  localparam port_load_t        HIGH_TH_L    = port_load_t'(HIGH_TH);
  localparam router_load_t      ROUTER_TH_L  = router_load_t'(ROUTER_HIGH_TH);
  localparam logic [2:0]        MIN_ACTIVE_L = 3'(MIN_ACTIVE);

  logic [EP_W-1:0]       epoch_cnt;
  logic                  load_valid;
  port_load_t            load [NUM_PORTS];
  port_stat_t            port_state [NUM_PORTS];
  logic [2:0]            active_cnt;
  logic                  cand_found;
  logic [1:0]            cand_idx;
  port_load_t            cand_load;
  logic                  epoch_eval;
  logic                  router_high;
  logic                  gate_ok;
  logic [NUM_PORTS-1:0]  gate_req;
  logic [NUM_PORTS-1:0]  wake_req;

  // Free-running epoch counter; the tracker samples on its last count.
  always_ff @(posedge clk) begin
    if (reset || epoch_cnt == EPOCH_LAST) begin
      epoch_cnt <= '0;
    end else begin
      epoch_cnt <= epoch_cnt + 1'b1;
    end
  end

  assign pgEnable = (epoch_cnt == EPOCH_LAST);

  // Loads returned by the tracker are valid one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_valid <= 1'b0;
    end else begin
      load_valid <= pgEnable;
    end
  end

  // Unpack per-port loads and count ports still drawing power.
  always_comb begin
    active_cnt = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      load[j] = portLoad[j*PG_PORT_LOAD_SIZE +: PG_PORT_LOAD_SIZE];
      if (port_state[j] != INACTIVE) active_cnt = active_cnt + 3'd1;
    end
  end

  // Pick the least-loaded ACTIVE port under LOW_TH; strict compare keeps
  // the lowest index on ties.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_load  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (port_state[j] == ACTIVE && load[j] < LOW_TH_L &&
          (!cand_found || load[j] < cand_load)) begin
        cand_found = 1'b1;
        cand_idx   = 2'(j);
        cand_load  = load[j];
      end
    end
  end

  assign epoch_eval  = load_valid && gateEn;
  assign router_high = (routerLoad >= ROUTER_TH_L);
  // A router-wide wake epoch never gates; the floor on powered ports holds.
  assign gate_ok     = epoch_eval && !router_high && cand_found &&
                       (active_cnt > MIN_ACTIVE_L);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    // Load-based wakes only concern INACTIVE ports, so the neighbour wake
    // and the epoch wake can share one FSM input.
    assign gate_req[g] = gate_ok && (cand_idx == 2'(g));
    assign wake_req[g] = wakeReq[g] ||
                         (epoch_eval && port_state[g] == INACTIVE &&
                          (load[g] >= HIGH_TH_L || router_high));

    pg_port_fsm #(
      .SLEEP_LAT (SLEEP_LAT),
      .WAKE_LAT  (WAKE_LAT)
    ) u_fsm (
      .clk     (clk),
      .reset   (reset),
      .gateReq (gate_req[g]),
      .wakeReq (wake_req[g]),
      .forceOn (!gateEn),
      .status  (port_state[g]),
      .powerOn (portPowerOn[g])
    );

    assign portStatus[g*PORT_STAT_SIZE +: PORT_STAT_SIZE] = port_state[g];
  end

endmodule
